// File: rtl/ppu_pkg.sv
// ppu_pkg
//   Constants shared by the PPU VRAM address path: scanline/dot numbers of
//   the scroll-register events and the bit positions of the fields inside
//   the 15-bit loopy address register v.
//   Layout of v (msb..lsb): {fv[2:0], v, h, vt[4:0], ht[4:0]}.
package ppu_pkg;

  localparam logic [9:0] PRERENDER_LINE = 10'd261;
  localparam logic [9:0] HCOPY_DOT      = 10'd257;
  localparam logic [9:0] VINC_DOT       = 10'd256;
  localparam logic [9:0] VCOPY_FIRST    = 10'd280;
  localparam logic [9:0] VCOPY_LAST     = 10'd304;
  localparam logic [9:0] CX_FIRST_DOT   = 10'd8;
  localparam logic [9:0] PREFETCH_CX0   = 10'd328;
  localparam logic [9:0] PREFETCH_CX1   = 10'd336;
  localparam logic [9:0] FETCH_A_FIRST  = 10'd1;
  localparam logic [9:0] FETCH_A_LAST   = 10'd256;
  localparam logic [9:0] FETCH_B_FIRST  = 10'd321;
  localparam logic [9:0] FETCH_B_LAST   = 10'd336;

  // Field offsets inside v.
  localparam int V_HT_LSB = 0;
  localparam int V_VT_LSB = 5;
  localparam int V_H_BIT  = 10;
  localparam int V_V_BIT  = 11;
  localparam int V_FV_LSB = 12;

  typedef enum logic [1:0] {
    PH_NT    = 2'd0,
    PH_AT    = 2'd1,
    PH_PT_LO = 2'd2,
    PH_PT_HI = 2'd3
  } fetch_phase_e;

  function automatic logic [14:0] pack_v(input logic [2:0] fv,
                                         input logic       nt_v,
                                         input logic       nt_h,
                                         input logic [4:0] vt,
                                         input logic [4:0] ht);
    return {fv, nt_v, nt_h, vt, ht};
  endfunction

endpackage

// File: rtl/ppu_vaddr_inc.sv
// ppu_vaddr_inc
//   Combinational coarse-x / vertical increment of a loopy v value.
//   Ports:
//     v_cur   in  15  current v
//     inc_x   in  1   apply coarse-x increment (ht wraps 31->0 and flips h)
//     inc_y   in  1   apply vertical increment (fine y, then coarse y)
//     v_next  out 15  incremented v
//   The two increments touch disjoint fields, so applying both together
//   gives the same result as coarse-x followed by vertical.
module ppu_vaddr_inc
  import ppu_pkg::*;
(
  input  logic [14:0] v_cur,
  input  logic        inc_x,
  input  logic        inc_y,
  output logic [14:0] v_next
);

  logic [4:0] ht;
  logic [4:0] vt;
  logic [2:0] fv;

  assign ht = v_cur[V_HT_LSB +: 5];
  assign vt = v_cur[V_VT_LSB +: 5];
  assign fv = v_cur[V_FV_LSB +: 3];

  always_comb begin
    v_next = v_cur;
    if (inc_x) begin
      if (ht == 5'd31) begin
        v_next[V_HT_LSB +: 5] = 5'd0;
        v_next[V_H_BIT]       = ~v_cur[V_H_BIT];
      end else begin
        v_next[V_HT_LSB +: 5] = ht + 5'd1;
      end
    end
    if (inc_y) begin
      if (fv != 3'd7) begin
        v_next[V_FV_LSB +: 3] = fv + 3'd1;
      end else begin
        v_next[V_FV_LSB +: 3] = 3'd0;
        // Row 29 is the last tile row of a nametable; rows 30/31 are the
        // attribute area and wrap without switching nametable.
        if (vt == 5'd29) begin
          v_next[V_VT_LSB +: 5] = 5'd0;
          v_next[V_V_BIT]       = ~v_cur[V_V_BIT];
        end else if (vt == 5'd31) begin
          v_next[V_VT_LSB +: 5] = 5'd0;
        end else begin
          v_next[V_VT_LSB +: 5] = vt + 5'd1;
        end
      end
    end
  end

endmodule

// File: rtl/ppu_vaddr.sv
// ppu_vaddr
//   Loopy VRAM address generator. Owns the 15-bit current-address register v,
//   updated by 0x2006 transfers, 0x2007 steps and the background fetch
//   schedule, and drives the registered 14-bit VRAM address.
//   Ports:
//     clk_in, rst_in           PPU clock, async active-low reset
//     dot_en_in                one-cycle strobe per PPU dot
//     nes_x_in, nes_y_in       current dot / scanline
//     ri_fv..ri_s              scroll latches from the register interface
//     ri_trans                 pulse: copy latches into v
//     ri_inc_addr(_amt)        pulse: 0x2007 access, step +1 / +32
//     ri_bg_en, ri_spr_en      rendering enables
//     vram_d_in                VRAM read data (nametable tile index)
//     vram_add_out             registered VRAM address
//     fine_x_out               ri_fh registered
//     fetch_phase_out          0 NT, 1 AT, 2 PT-lo, 3 PT-hi
//     fetch_act_out            inside the fetch window
module ppu_vaddr
  import ppu_pkg::*;
#(
  parameter int VIS_LINES = 240
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        dot_en_in,
  input  logic [9:0]  nes_x_in,
  input  logic [9:0]  nes_y_in,
  input  logic [2:0]  ri_fv,
  input  logic [4:0]  ri_vt,
  input  logic        ri_v,
  input  logic [2:0]  ri_fh,
  input  logic [4:0]  ri_ht,
  input  logic        ri_h,
  input  logic        ri_s,
  input  logic        ri_trans,
  input  logic        ri_inc_addr,
  input  logic        ri_inc_addr_amt,
  input  logic        ri_bg_en,
  input  logic        ri_spr_en,
  input  logic [7:0]  vram_d_in,
  output logic [13:0] vram_add_out,
  output logic [2:0]  fine_x_out,
  output logic [1:0]  fetch_phase_out,
  output logic        fetch_act_out
);

  localparam logic [9:0] VIS_LINES_W = 10'(VIS_LINES);

  logic [14:0]  v_q;
  logic [14:0]  v_nxt;
  logic [14:0]  v_inc;
  logic [14:0]  v_latch;
  logic [7:0]   tile_q;
  logic [13:0]  addr_nxt;

  logic         rendering;
  logic         render_line;
  logic         render_evt;
  logic         in_window;
  fetch_phase_e phase;

  logic         dot_cx;
  logic         dot_vinc;
  logic         dot_hcopy;
  logic         dot_vcopy;
  logic         glitch_inc;
  logic         tile_cap;

  assign rendering   = ri_bg_en | ri_spr_en;
  assign render_line = (nes_y_in < VIS_LINES_W) || (nes_y_in == PRERENDER_LINE);
  assign render_evt  = rendering & render_line;

  assign in_window = render_evt &&
                     (((nes_x_in >= FETCH_A_FIRST) && (nes_x_in <= FETCH_A_LAST)) ||
                      ((nes_x_in >= FETCH_B_FIRST) && (nes_x_in <= FETCH_B_LAST)));

  // ((x-1)>>1)&3 folded onto x[2:0]: even dots belong to the pair that
  // started on the preceding odd dot.
  assign phase = fetch_phase_e'(nes_x_in[2:1] - {1'b0, ~nes_x_in[0]});

  assign dot_cx = render_evt & dot_en_in &
                  (((nes_x_in[2:0] == 3'd0) && (nes_x_in >= CX_FIRST_DOT) &&
                    (nes_x_in <= VINC_DOT)) ||
                   (nes_x_in == PREFETCH_CX0) || (nes_x_in == PREFETCH_CX1));
  assign dot_vinc  = render_evt & dot_en_in & (nes_x_in == VINC_DOT);
  assign dot_hcopy = render_evt & dot_en_in & (nes_x_in == HCOPY_DOT);
  assign dot_vcopy = render_evt & dot_en_in & (nes_y_in == PRERENDER_LINE) &
                     (nes_x_in >= VCOPY_FIRST) & (nes_x_in <= VCOPY_LAST);

  // A 0x2007 access during rendering bumps both counters at once; OR-ing it
  // with the scheduled events keeps a coincident dot event from counting twice.
  assign glitch_inc = render_evt & ri_inc_addr;

  assign tile_cap = in_window & dot_en_in & (nes_x_in[2:0] == 3'd2);

  assign v_latch = pack_v(ri_fv, ri_v, ri_h, ri_vt, ri_ht);

  ppu_vaddr_inc u_inc (
    .v_cur  (v_q),
    .inc_x  (dot_cx | glitch_inc),
    .inc_y  (dot_vinc | glitch_inc),
    .v_next (v_inc)
  );

  always_comb begin
    v_nxt = v_q;
    if (ri_trans) begin
      v_nxt = v_latch;
    end else begin
      if (ri_inc_addr && !render_evt) begin
        v_nxt = v_q + (ri_inc_addr_amt ? 15'd32 : 15'd1);
      end else begin
        v_nxt = v_inc;
      end
      if (dot_hcopy) begin
        v_nxt[V_HT_LSB +: 5] = ri_ht;
        v_nxt[V_H_BIT]       = ri_h;
      end
      if (dot_vcopy) begin
        v_nxt[V_FV_LSB +: 3] = ri_fv;
        v_nxt[V_VT_LSB +: 5] = ri_vt;
        v_nxt[V_V_BIT]       = ri_v;
      end
    end
  end

  always_comb begin
    addr_nxt = v_q[13:0];
    if (in_window) begin
      unique case (phase)
        PH_NT:    addr_nxt = {2'b10, v_q[V_V_BIT], v_q[V_H_BIT],
                              v_q[V_VT_LSB +: 5], v_q[V_HT_LSB +: 5]};
        PH_AT:    addr_nxt = {2'b10, v_q[V_V_BIT], v_q[V_H_BIT], 4'b1111,
                              v_q[V_VT_LSB + 2 +: 3], v_q[V_HT_LSB + 2 +: 3]};
        PH_PT_LO: addr_nxt = {1'b0, ri_s, tile_q, 1'b0, v_q[V_FV_LSB +: 3]};
        PH_PT_HI: addr_nxt = {1'b0, ri_s, tile_q, 1'b1, v_q[V_FV_LSB +: 3]};
        default:  addr_nxt = v_q[13:0];
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      v_q             <= '0;
      tile_q          <= '0;
      vram_add_out    <= '0;
      fine_x_out      <= '0;
      fetch_phase_out <= '0;
      fetch_act_out   <= 1'b0;
    end else begin
      v_q             <= v_nxt;
      if (tile_cap) tile_q <= vram_d_in;
      vram_add_out    <= addr_nxt;
      fine_x_out      <= ri_fh;
      fetch_phase_out <= in_window ? phase : PH_NT;
      fetch_act_out   <= in_window;
    end
  end

endmodule

// File: tb/tb_ppu_vaddr.sv
// Testbench for ppu_vaddr: directed scenarios with literal expectations plus
// randomized dot/line traffic, all compared every cycle against a field-level
// arithmetic model of the loopy address register.
module tb_ppu_vaddr;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        dot_en = 1'b0;
  logic [9:0]  nes_x = '0;
  logic [9:0]  nes_y = '0;
  logic [2:0]  lat_fv = '0;
  logic [4:0]  lat_vt = '0;
  logic        lat_v = 1'b0;
  logic [2:0]  lat_fh = '0;
  logic [4:0]  lat_ht = '0;
  logic        lat_h = 1'b0;
  logic        lat_s = 1'b0;
  logic        trans = 1'b0;
  logic        inc = 1'b0;
  logic        inc_amt = 1'b0;
  logic        bg_en = 1'b0;
  logic        spr_en = 1'b0;
  logic [7:0]  vram_d = '0;
  logic [13:0] vram_add;
  logic [2:0]  fine_x;
  logic [1:0]  fetch_phase;
  logic        fetch_act;

  int n_checks = 0;
  int n_err    = 0;

  // Model state: fine y, nametable (v*2+h), coarse y, coarse x, tile.
  int m_fv = 0, m_nt = 0, m_vt = 0, m_ht = 0, m_tile = 0;

  always #5 clk = ~clk;

  ppu_vaddr #(.VIS_LINES(240)) dut (
    .clk_in          (clk),
    .rst_in          (rst_n),
    .dot_en_in       (dot_en),
    .nes_x_in        (nes_x),
    .nes_y_in        (nes_y),
    .ri_fv           (lat_fv),
    .ri_vt           (lat_vt),
    .ri_v            (lat_v),
    .ri_fh           (lat_fh),
    .ri_ht           (lat_ht),
    .ri_h            (lat_h),
    .ri_s            (lat_s),
    .ri_trans        (trans),
    .ri_inc_addr     (inc),
    .ri_inc_addr_amt (inc_amt),
    .ri_bg_en        (bg_en),
    .ri_spr_en       (spr_en),
    .vram_d_in       (vram_d),
    .vram_add_out    (vram_add),
    .fine_x_out      (fine_x),
    .fetch_phase_out (fetch_phase),
    .fetch_act_out   (fetch_act)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int m_pack();
    return m_fv * 4096 + m_nt * 1024 + m_vt * 32 + m_ht;
  endfunction

  // Reference model: evaluated on each rising edge from the inputs held
  // since the previous falling edge, then compared just after the edge.
  always @(posedge clk) begin : model
    int x, y, flat, hx, e_addr, e_ph, e_act, e_fx;
    bit rend, rl, win, ev, do_cx, do_vi;
    if (!rst_n) begin
      m_fv = 0; m_nt = 0; m_vt = 0; m_ht = 0; m_tile = 0;
      e_addr = 0; e_ph = 0; e_act = 0; e_fx = 0;
    end else begin
      x    = int'(nes_x);
      y    = int'(nes_y);
      rend = bg_en || spr_en;
      rl   = (y < 240) || (y == 261);
      ev   = rend && rl;
      win  = ev && ((x >= 1 && x <= 256) || (x >= 321 && x <= 336));
      e_act = win ? 1 : 0;
      e_ph  = win ? ((x - 1) / 2) % 4 : 0;
      e_fx  = int'(lat_fh);
      if (!win) e_addr = (m_fv % 4) * 4096 + m_nt * 1024 + m_vt * 32 + m_ht;
      else begin
        case (e_ph)
          0:       e_addr = 8192 + m_nt * 1024 + m_vt * 32 + m_ht;
          1:       e_addr = 8192 + m_nt * 1024 + 960 + (m_vt / 4) * 8 + m_ht / 4;
          2:       e_addr = int'(lat_s) * 4096 + m_tile * 16 + m_fv;
          default: e_addr = int'(lat_s) * 4096 + m_tile * 16 + 8 + m_fv;
        endcase
      end
      if (win && dot_en && (x % 8 == 2)) m_tile = int'(vram_d);
      if (trans) begin
        m_fv = int'(lat_fv); m_vt = int'(lat_vt);
        m_nt = int'(lat_v) * 2 + int'(lat_h); m_ht = int'(lat_ht);
      end else begin
        do_cx = ev && ((dot_en && ((x % 8 == 0 && x >= 8 && x <= 256) || x == 328 || x == 336)) || inc);
        do_vi = ev && ((dot_en && x == 256) || inc);
        if (inc && !ev) begin
          flat = (m_pack() + (inc_amt ? 32 : 1)) % 32768;
          m_fv = flat / 4096; m_nt = (flat / 1024) % 4;
          m_vt = (flat / 32) % 32; m_ht = flat % 32;
        end
        if (do_cx) begin
          hx = ((m_nt % 2) * 32 + m_ht + 1) % 64;
          m_ht = hx % 32;
          m_nt = (m_nt / 2) * 2 + hx / 32;
        end
        if (do_vi) begin
          if (m_fv < 7) m_fv = m_fv + 1;
          else begin
            m_fv = 0;
            if (m_vt == 29) begin m_vt = 0; m_nt = m_nt ^ 2; end
            else if (m_vt == 31) m_vt = 0;
            else m_vt = m_vt + 1;
          end
        end
        if (ev && dot_en && x == 257) begin
          m_ht = int'(lat_ht); m_nt = (m_nt / 2) * 2 + int'(lat_h);
        end
        if (ev && dot_en && y == 261 && x >= 280 && x <= 304) begin
          m_fv = int'(lat_fv); m_vt = int'(lat_vt);
          m_nt = int'(lat_v) * 2 + (m_nt % 2);
        end
      end
    end
    #1;
    chk("model_addr",   int'(vram_add),    e_addr);
    chk("model_phase",  int'(fetch_phase), e_ph);
    chk("model_act",    int'(fetch_act),   e_act);
    chk("model_fine_x", int'(fine_x),      e_fx);
  end

  task automatic set_lat(input int fv, input int vt, input int vv, input int h, input int ht);
    lat_fv = 3'(fv); lat_vt = 5'(vt); lat_v = 1'(vv); lat_h = 1'(h); lat_ht = 5'(ht);
  endtask

  // Called right after a falling edge; returns one falling edge later.
  task automatic load_v(input int fv, input int vt, input int vv, input int h, input int ht);
    set_lat(fv, vt, vv, h, ht);
    trans = 1'b1;
    @(negedge clk);
    trans = 1'b0;
  endtask

  task automatic rand_latches();
    lat_fv = 3'($urandom); lat_vt = 5'($urandom); lat_v = 1'($urandom);
    lat_h  = 1'($urandom); lat_ht = 5'($urandom);
  endtask

  int exp_a[8] = '{14'h2000, 14'h2000, 14'h23C0, 14'h23C0, 14'h1A53, 14'h1A53, 14'h1A5B, 14'h1A5B};
  int exp_p[8] = '{0, 0, 1, 1, 2, 2, 3, 3};

  initial begin
    // Reset state, with ri_fh non-zero to show fine_x is held.
    lat_fh = 3'd5;
    repeat (3) @(negedge clk);
    chk("rst_addr",   int'(vram_add), 0);
    chk("rst_fine_x", int'(fine_x), 0);
    chk("rst_phase",  int'(fetch_phase), 0);
    chk("rst_act",    int'(fetch_act), 0);
    rst_n = 1'b1; lat_fh = 3'd0;
    @(negedge clk);

    // Transfer latency: v at N+1, address at N+2.
    load_v(5, 26, 1, 0, 3);
    chk("t1_latency", int'(vram_add), 0);
    @(negedge clk);
    chk("t1_load", int'(vram_add), 14'h1B43);

    // +1 step across 0x3FFF, then +32 wrapping the 15-bit counter.
    load_v(3, 31, 1, 1, 31);
    inc = 1'b1; inc_amt = 1'b0;
    @(negedge clk);
    inc = 1'b0;
    chk("t2_pre", int'(vram_add), 14'h3FFF);
    @(negedge clk);
    chk("t2_step1", int'(vram_add), 14'h0000);
    load_v(7, 31, 1, 1, 16);
    inc = 1'b1; inc_amt = 1'b1;
    @(negedge clk);
    inc = 1'b0; inc_amt = 1'b0;
    chk("t2_pre32", int'(vram_add), 14'h3FF0);
    @(negedge clk);
    chk("t2_wrap32", int'(vram_add), 14'h0010);

    // Coarse-x wrap at dot 8, then dot 256 with fv=7, vt=29.
    nes_y = 10'd10; nes_x = 10'd0;
    load_v(7, 29, 0, 0, 31);
    bg_en = 1'b1; nes_x = 10'd8; dot_en = 1'b1;
    @(negedge clk);
    nes_x = 10'd0; dot_en = 1'b0;
    @(negedge clk);
    chk("t3_cx_wrap", int'(vram_add), 14'h37A0);
    nes_x = 10'd256; dot_en = 1'b1;
    @(negedge clk);
    nes_x = 10'd0; dot_en = 1'b0;
    @(negedge clk);
    chk("t3_vinc", int'(vram_add), 14'h0C01);

    // One 8-dot fetch group with tile 0xA5 presented only at dot 2.
    lat_s = 1'b1;
    load_v(3, 0, 0, 0, 0);
    nes_x = 10'd1; dot_en = 1'b1; vram_d = 8'($urandom);
    for (int d = 1; d <= 8; d++) begin
      @(negedge clk);
      chk("t4_addr", int'(vram_add), exp_a[d-1]);
      chk("t4_phase", int'(fetch_phase), exp_p[d-1]);
      if (d < 8) begin
        nes_x = 10'(d + 1);
        vram_d = (d + 1 == 2) ? 8'hA5 : 8'($urandom);
      end else begin
        nes_x = 10'd0; dot_en = 1'b0;
      end
    end

    // Vertical copy on the pre-render line; horizontal fields untouched.
    nes_y = 10'd261; lat_s = 1'b0;
    load_v(0, 0, 0, 1, 7);
    set_lat(6, 21, 1, 0, 18);
    dot_en = 1'b1;
    for (int x = 280; x <= 304; x++) begin
      nes_x = 10'(x);
      @(negedge clk);
    end
    nes_x = 10'd0; dot_en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("t5_vcopy", int'(vram_add), 14'h2EA7);
    nes_y = 10'd0; nes_x = 10'd257; dot_en = 1'b1;
    @(negedge clk);
    nes_x = 10'd0; dot_en = 1'b0;
    @(negedge clk);
    chk("t5_hcopy", int'(vram_add), 14'h2AB2);

    // Transfer coincident with dot 256 wins over both increments.
    nes_y = 10'd10; nes_x = 10'd256; dot_en = 1'b1;
    set_lat(7, 29, 0, 0, 31);
    trans = 1'b1;
    @(negedge clk);
    trans = 1'b0; nes_x = 10'd0; dot_en = 1'b0;
    @(negedge clk);
    chk("t6_trans_prio", int'(vram_add), 14'h33BF);

    // Asynchronous reset in the middle of a fetch group.
    nes_x = 10'd5; dot_en = 1'b1; lat_fh = 3'd6;
    @(negedge clk);
    chk("t7_act_pre", int'(fetch_act), 1);
    nes_x = 10'd6;
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("t7_rst_addr",   int'(vram_add), 0);
    chk("t7_rst_phase",  int'(fetch_phase), 0);
    chk("t7_rst_act",    int'(fetch_act), 0);
    chk("t7_rst_fine_x", int'(fine_x), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1; dot_en = 1'b0; bg_en = 1'b0;
    @(negedge clk);

    // Randomized traffic across visible, vblank and pre-render lines.
    for (int seg = 0; seg < 160; seg++) begin
      case ($urandom_range(0, 3))
        0:       nes_y = 10'($urandom_range(240, 260));
        1:       nes_y = 10'd261;
        default: nes_y = 10'($urandom_range(0, 239));
      endcase
      case ($urandom_range(0, 5))
        0: nes_x = 10'd0;
        1: nes_x = 10'd248;
        2: nes_x = 10'd276;
        3: nes_x = 10'd300;
        4: nes_x = 10'd318;
        default: nes_x = 10'($urandom_range(0, 340));
      endcase
      bg_en  = ($urandom_range(0, 3) != 0);
      spr_en = 1'($urandom);
      rand_latches();
      for (int c = 0; c < 48; c++) begin
        dot_en  = ($urandom_range(0, 3) != 0);
        trans   = ($urandom_range(0, 24) == 0);
        inc     = ($urandom_range(0, 11) == 0);
        inc_amt = 1'($urandom);
        vram_d  = 8'($urandom);
        lat_fh  = 3'($urandom);
        lat_s   = 1'($urandom);
        if ($urandom_range(0, 29) == 0) rand_latches();
        if ($urandom_range(0, 59) == 0) bg_en = ~bg_en;
        @(negedge clk);
        if (dot_en) begin
          if (nes_x == 10'd340) begin
            nes_x = 10'd0;
            nes_y = (nes_y == 10'd261) ? 10'd0 : nes_y + 10'd1;
          end else begin
            nes_x = nes_x + 10'd1;
          end
        end
      end
    end
    dot_en = 1'b0; trans = 1'b0; inc = 1'b0;
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
